serial_sub: RTL and testbench

- Bit-serial unsigned subtractor with borrow-in and borrow-out.
- It is the inverse arithmetic companion of the team's 4-bit ripple adder with carry-in and carry-out (ex3).
- It computes d = a - b - bin one bit per clock, LSB first, under a start/done handshake.
- It serves as the exercise block for sequential datapath plus FSM in the course material, and its results cross-check the adder: a = d + b + bin.

---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/serial_sub_full_sub.sv | 18 +
 rtl/serial_sub.sv | 108 ++++++++++
 tb/tb_serial_sub.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
//   sub_state_t : FSM state encoding (IDLE, RUN, DONE)
//   cnt_width   : bit-position counter width for a given operand width
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Counter must index bits 0..w-1; floor at 1 bit so the vector is never empty.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// Single-bit full subtractor cell: diff = x - y - bi, with borrow out.
//   x, y : operand bits
//   bi   : borrow in
//   diff : difference bit
//   bo   : borrow out
module full_sub (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  assign diff = x ^ y ^ bi;
  // Borrow when y exceeds x, or when they match and a borrow is pending.
  assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: d = a - b - bin, one bit per clock, LSB first.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   start    : request (accepted only in IDLE), a/b/bin sampled on that edge
//   busy     : high while bits are being processed
//   done     : one-cycle pulse when d and bout are valid
//   d, bout  : difference mod 2^WIDTH and borrow out of the MSB
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int unsigned     CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  sub_state_t       state;
  sub_state_t       state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic [CNT_W-1:0] count;
  logic             diff_c;
  logic             bo_c;
  logic             last_c;

  // Per-bit cell always looks at the LSB of the shifting operands.
  full_sub u_cell (
    .x   (a_sr[0]),
    .y   (b_sr[0]),
    .bi  (brw),
    .diff(diff_c),
    .bo  (bo_c)
  );

  assign last_c = (count == LAST);

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      brw   <= 1'b0;
      count <= '0;
    end else begin
      // Status flags track the state being entered so they line up with it.
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= bin;
            count <= '0;
          end
        end
        RUN: begin
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          brw   <= bo_c;
          // Result fills from the MSB so bit 0 lands in place after WIDTH shifts.
          res   <= {diff_c, res[WIDTH-1:1]};
          count <= count + CNT_W'(1);
          if (last_c) begin
            d    <= {diff_c, res[WIDTH-1:1]};
            bout <= bo_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=4) against an arithmetic model.
module tb_serial_sub;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;

  int n_tests;
  int n_fail;

  serial_sub #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .d    (d),
    .bout (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic, borrow when the true result is negative.
  function automatic int ref_d(input int x, input int y, input int z);
    return (x - y - z) & 15;
  endfunction

  function automatic int ref_bout(input int x, input int y, input int z);
    return (x - y - z < 0) ? 1 : 0;
  endfunction

  // Issue one subtraction from IDLE and verify latency, busy width, result,
  // the adder round trip and the done pulse width. Operands are scrambled
  // right after acceptance to show they are not re-sampled.
  task automatic run_op(input int x, input int y, input int z, input string tag);
    int k;
    int bc;
    int s;
    @(negedge clk);
    a = W'(x); b = W'(y); bin = z[0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    k = 0; bc = 0;
    while (!done && k < 20) begin
      if (busy) bc++;
      @(posedge clk); #1;
      k++;
    end
    chk({tag, " latency"}, k, W);
    chk({tag, " busy_cycles"}, bc, W);
    chk({tag, " d"}, int'(d), ref_d(x, y, z));
    chk({tag, " bout"}, int'(bout), ref_bout(x, y, z));
    // Adder cross-check: d + b + bin must give back a with carry = bout.
    s = int'(d) + y + z;
    chk({tag, " add_s"}, s & 15, x);
    chk({tag, " add_cout"}, (s >> 4) & 1, ref_bout(x, y, z));
    @(posedge clk); #1;
    chk({tag, " done_width"}, int'(done), 0);
    chk({tag, " busy_after"}, int'(busy), 0);
  endtask

  typedef struct {
    int x; int y; int z; int ed; int eb;
  } vec_t;

  initial begin
    vec_t sweep[6];
    int last_done;
    int pulses;
    int was_done;
    int x, y, z;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;

    // Reset, with start asserted to show reset priority.
    @(negedge clk); start = 1'b1; a = 4'd5; b = 4'd4;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst d", int'(d), 0);
    chk("rst bout", int'(bout), 0);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    run_op(5, 4, 0, "first");
    chk("first d const", int'(d), 1);

    // Directed sweep with hand-computed expectations.
    sweep[0] = '{5, 4, 1, 0, 0};
    sweep[1] = '{3, 9, 1, 9, 1};
    sweep[2] = '{3, 9, 0, 10, 1};
    sweep[3] = '{8, 9, 0, 15, 1};
    sweep[4] = '{0, 0, 1, 15, 1};
    sweep[5] = '{15, 0, 0, 15, 0};
    foreach (sweep[i]) begin
      run_op(sweep[i].x, sweep[i].y, sweep[i].z, $sformatf("sweep%0d", i));
      chk($sformatf("sweep%0d d const", i), int'(d), sweep[i].ed);
      chk($sformatf("sweep%0d bout const", i), int'(bout), sweep[i].eb);
    end

    // Hold: last sweep-like op 3-9-0, then idle for 10 cycles.
    run_op(3, 9, 0, "hold_op");
    repeat (10) begin
      @(posedge clk); #1;
      chk("hold done", int'(done), 0);
    end
    chk("hold d", int'(d), 10);
    chk("hold bout", int'(bout), 1);

    // Exhaustive over all operand/borrow combinations.
    for (int i = 0; i < 512; i++) begin
      run_op((i >> 5) & 15, (i >> 1) & 15, i & 1, $sformatf("exh%0d", i));
    end

    // Random ops with random idle gaps.
    repeat (40) begin
      x = int'($urandom_range(15, 0));
      y = int'($urandom_range(15, 0));
      z = int'($urandom_range(1, 0));
      repeat ($urandom_range(3, 0)) @(posedge clk);
      run_op(x, y, z, "rand");
    end

    // start held high: one accept every W+2 cycles, operands garbage mid-RUN.
    @(negedge clk); a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
    last_done = -1; pulses = 0; was_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (busy) begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end else begin
        a = 4'd7; b = 4'd2; bin = 1'b0;
      end
      if (done) begin
        chk("cont d", int'(d), 5);
        chk("cont bout", int'(bout), 0);
        if (last_done >= 0) chk("cont interval", c - last_done, W + 2);
        last_done = c;
        pulses++;
      end
      if (was_done != 0) chk("cont done_width", int'(done), 0);
      was_done = int'(done);
    end
    chk("cont pulses", pulses, 6);
    @(negedge clk); start = 1'b0;
    repeat (W + 3) @(posedge clk);

    // Reset during RUN aborts without a done pulse.
    @(negedge clk); a = 4'd3; b = 4'd9; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort d", int'(d), 0);
    chk("abort bout", int'(bout), 0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("abort no_done", pulses, 0);
    run_op(5, 4, 0, "post_abort");
    chk("post_abort d const", int'(d), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
